ahb_req_capture: RTL
====================

# ahb_req_capture

Slave-side AHB front end of the bridge. It sits directly downstream of the AHB master on the shared HCLK/HRESETn bus, in the slave position. It converts AHB address and data phases into a buffered request stream for the bridge core. It also returns read data and HREADY/HRESP to the master.

## Interface
- AHB_DATA_WIDTH, 64, HWDATA/HRDATA/req_wdata/rsp_rdata width; power of two, 8..1024
- AHB_ADDRESS_WIDTH, 32, HADDR/req_addr width
- FIFO_DEPTH, 4, request FIFO entries; power of two, >=2
- HCLK  in  1  single clock, all state on rising edge
- HRESETn  in  1  reset, asynchronous assert, active-low
- HADDR  in  AHB_ADDRESS_WIDTH  address-phase address
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  log2 bytes per beat
- HBURST  in  3  000 SINGLE, 001 INCR, 010 WRAP4, 011 INCR4, 100 WRAP8, 101 INCR8, 110 WRAP16, 111 INCR16
- HWDATA  in  AHB_DATA_WIDTH  write data, data phase
- HREADY  out  1  transfer complete / wait state
- HRESP  out  1  0 OKAY, 1 ERROR
- HRDATA  out  AHB_DATA_WIDTH  read data
- req_valid  out  1  FIFO head valid
- req_ready  in  1  core accepts head
- req_addr  out  AHB_ADDRESS_WIDTH  head address
- req_write  out  1  head direction
- req_size  out  3  head HSIZE
- req_wdata  out  AHB_DATA_WIDTH  head write data; 0 for reads
- req_last  out  1  head is final beat of its burst
- rsp_valid  in  1  one-cycle read-data strobe from core
- rsp_rdata  in  AHB_DATA_WIDTH  read data qualified by rsp_valid

## Operation
- FSM states:
  - ADDR: no data phase pending.
  - WR: write data phase.
  - RD: read data phase, request not yet pushed.
  - RWAIT: read request pushed, waiting for rsp_valid.
  - RDONE: read data returned.
  - ERR1, ERR2: two-cycle ERROR response.
- HREADY is 1 in ADDR, RDONE and ERR2.
  - In WR, HREADY = (count < FIFO_DEPTH).
  - In RD, RWAIT and ERR1, HREADY is 0.
- HRESP is 1 only in ERR1 and ERR2.
- Address-phase sampling occurs on any edge where HREADY=1.
  - HTRANS NONSEQ or SEQ with HSIZE > log2(AHB_DATA_WIDTH/8): go to ERR1. No push; the beat counter is still updated.
  - HTRANS NONSEQ or SEQ otherwise: register HADDR/HWRITE/HSIZE and go to WR (write) or RD (read).
  - IDLE or BUSY: go to ADDR. No push, OKAY response.
- Beat counter:
  - NONSEQ loads beats_left = burst length − 1. SINGLE=0, *4=3, *8=7, *16=15, INCR=0.
  - SEQ decrements beats_left, saturating at 0.
- last flag, computed in the data phase:
  - Fixed-length bursts and SINGLE: last = (beats_left==0).
  - INCR: last = 1 iff HTRANS on the bus in that cycle is IDLE or NONSEQ.
  - INCR bursts are never terminated by BUSY in this design.
- WR: when count < FIFO_DEPTH, push {addr, 1, size, HWDATA, last}, then take the address-phase transition. Otherwise stay.
- RD: when count < FIFO_DEPTH, push {addr, 0, size, 0, last} and go to RWAIT.
- RWAIT: on rsp_valid, register HRDATA <= rsp_rdata and go to RDONE. HRDATA holds until the next read.
- RDONE, ERR2: take the address-phase transition.
- ERR1 → ERR2 unconditionally.
- rsp_valid outside RWAIT is ignored.
- FIFO:
  - req_valid = (count != 0); req_* are driven from the head entry.
  - Pop when req_valid && req_ready.
  - Push is qualified by the registered count only: a full FIFO rejects a push even if a pop occurs the same cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
- Ordering: strictly in AHB order. The core returns a read response only after all older FIFO entries have been consumed.
- Reset (any time, including mid-burst or in RWAIT):
  - State ADDR, count 0, beats_left 0, pointers 0.
  - Outputs: HREADY=1, HRESP=0, HRDATA=0, req_valid=0.
  - In-flight requests are discarded.

## Timing
- HREADY and HRESP are combinational from registered state and count only; there is no input→output combinational path.
- Write with no backpressure:
  - Address phase at cycle T.
  - Data phase at T+1: HREADY=1, push on the T+1 edge.
  - req_valid at T+2.
- Read:
  - Address phase at T; push at the end of T+1 (HREADY=0).
  - req_valid at T+2.
  - rsp_valid at cycle R ≥ T+2 gives HRDATA valid and HREADY=1 at R+1.
  - Minimum data-phase length is 3 cycles.
- Error: ERR1 at T+1 (HREADY=0, HRESP=1), then ERR2 at T+2 (HREADY=1, HRESP=1).
- Back-to-back writes sustain 1 beat/cycle while count < FIFO_DEPTH.

## Test plan
- SINGLE write, HADDR=0x100, HWDATA=0xA5A5, req_ready=1:
  - HREADY never low.
  - One request {0x100, write, size 3, 0xA5A5, last=1} with req_valid at T+2.
- INCR4 write at 0x200, size 3, req_ready=1:
  - Four requests at 0x200/0x208/0x210/0x218.
  - req_last=1 only on 0x218.
- INCR8 write with req_ready=0, FIFO_DEPTH=4:
  - Beats 1–4 accepted.
  - HREADY=0 in the beat-5 data phase until req_ready=1; then 1 beat/cycle.
  - All 8 requests in order.
- SINGLE read at 0x40, core asserts rsp_valid with 0xDEADBEEF two cycles after req pop:
  - HREADY=0 until the cycle after rsp_valid, then HRDATA=0xDEADBEEF with HREADY=1.
- NONSEQ with HSIZE=4 (128-bit on 64-bit bus):
  - HREADY/HRESP = 0/1 then 1/1.
  - No request pushed; next transfer proceeds normally.
- HRESETn low during RWAIT with 3 entries queued:
  - Immediately req_valid=0, HREADY=1, HRESP=0, HRDATA=0.
  - After release, a new SINGLE write completes normally.

Source files
------------

// File: rtl/ahb_req_capture_if.sv
// AHB slave-side bus plus the request/response stream toward the bridge core.
interface ahb_req_capture_if #(
  parameter int unsigned AHB_DATA_WIDTH    = 64,
  parameter int unsigned AHB_ADDRESS_WIDTH = 32
);
  logic [AHB_ADDRESS_WIDTH-1:0] HADDR;
  logic [1:0]                   HTRANS;
  logic                         HWRITE;
  logic [2:0]                   HSIZE;
  logic [2:0]                   HBURST;
  logic [AHB_DATA_WIDTH-1:0]    HWDATA;
  logic                         HREADY;
  logic                         HRESP;
  logic [AHB_DATA_WIDTH-1:0]    HRDATA;

  logic                         req_valid;
  logic                         req_ready;
  logic [AHB_ADDRESS_WIDTH-1:0] req_addr;
  logic                         req_write;
  logic [2:0]                   req_size;
  logic [AHB_DATA_WIDTH-1:0]    req_wdata;
  logic                         req_last;
  logic                         rsp_valid;
  logic [AHB_DATA_WIDTH-1:0]    rsp_rdata;

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  req_ready, rsp_valid, rsp_rdata,
    output HREADY, HRESP, HRDATA,
    output req_valid, req_addr, req_write, req_size, req_wdata, req_last
  );

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output req_ready, rsp_valid, rsp_rdata,
    input  HREADY, HRESP, HRDATA,
    input  req_valid, req_addr, req_write, req_size, req_wdata, req_last
  );
endinterface

// File: rtl/ahb_req_capture.sv
// AHB slave front end: captures address/data phases into a request FIFO for the
// bridge core and returns HRDATA/HREADY/HRESP to the master.
module ahb_req_capture #(
  parameter int unsigned AHB_DATA_WIDTH    = 64,
  parameter int unsigned AHB_ADDRESS_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahb_req_capture_if.slave bus
);
  localparam int unsigned DW       = AHB_DATA_WIDTH;
  localparam int unsigned AW       = AHB_ADDRESS_WIDTH;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned MAX_SIZE = $clog2(DW / 8);
  localparam int unsigned BEAT_W   = 4;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR = 3'b001;

  typedef enum logic [2:0] {
    ST_ADDR, ST_WR, ST_RD, ST_RWAIT, ST_RDONE, ST_ERR1, ST_ERR2
  } state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [2:0]    size;
    logic [DW-1:0] wdata;
    logic          last;
  } req_t;

  state_e              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic                incr_q, incr_d;
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]       hrdata_q, hrdata_d;
  req_t                mem_q [FIFO_DEPTH];
  req_t                mem_d [FIFO_DEPTH];

  logic                space_c, hready_c, hresp_c;
  logic                xfer_c, size_err_c, last_c, push_c, pop_c;
  logic [BEAT_W-1:0]   burst_len_m1_c;
  req_t                entry_c, head_c;

  assign space_c    = (count_q < CNT_W'(FIFO_DEPTH));
  assign xfer_c     = (bus.HTRANS == TR_NONSEQ) || (bus.HTRANS == TR_SEQ);
  assign size_err_c = (bus.HSIZE > 3'(MAX_SIZE));
  assign pop_c      = (count_q != '0) && bus.req_ready;

  // INCR bursts end when the bus shows IDLE or a fresh NONSEQ behind the current beat
  assign last_c = incr_q ? ((bus.HTRANS == TR_IDLE) || (bus.HTRANS == TR_NONSEQ))
                         : (beats_q == '0);

  // HREADY/HRESP depend on registered state and count only
  always_comb begin
    hready_c = 1'b0;
    hresp_c  = 1'b0;
    unique case (state_q)
      ST_ADDR, ST_RDONE: hready_c = 1'b1;
      ST_WR:             hready_c = space_c;
      ST_ERR1:           hresp_c  = 1'b1;
      ST_ERR2: begin
        hready_c = 1'b1;
        hresp_c  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    burst_len_m1_c = '0;
    unique case (bus.HBURST)
      3'b010, 3'b011: burst_len_m1_c = BEAT_W'(3);
      3'b100, 3'b101: burst_len_m1_c = BEAT_W'(7);
      3'b110, 3'b111: burst_len_m1_c = BEAT_W'(15);
      default:        burst_len_m1_c = '0;
    endcase
  end

  // Data-phase progress, then the address-phase transition whenever HREADY is high
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    incr_d   = incr_q;
    beats_d  = beats_q;
    hrdata_d = hrdata_q;
    push_c   = 1'b0;
    unique case (state_q)
      ST_WR: push_c = space_c;
      ST_RD: begin
        if (space_c) begin
          push_c  = 1'b1;
          state_d = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (bus.rsp_valid) begin
          hrdata_d = bus.rsp_rdata;
          state_d  = ST_RDONE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: ;
    endcase
    if (hready_c) begin
      state_d = ST_ADDR;
      if (xfer_c) begin
        if (bus.HTRANS == TR_NONSEQ) begin
          beats_d = burst_len_m1_c;
        end else begin
          beats_d = (beats_q == '0) ? '0 : beats_q - BEAT_W'(1);
        end
        if (size_err_c) begin
          state_d = ST_ERR1;
        end else begin
          state_d = bus.HWRITE ? ST_WR : ST_RD;
          addr_d  = bus.HADDR;
          size_d  = bus.HSIZE;
          incr_d  = (bus.HBURST == BURST_INCR);
        end
      end
    end
  end

  // Request FIFO; a full FIFO refuses a push even when it pops in the same cycle
  always_comb begin
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    entry_c.addr   = addr_q;
    entry_c.write  = (state_q == ST_WR);
    entry_c.size   = size_q;
    entry_c.wdata  = (state_q == ST_WR) ? bus.HWDATA : '0;
    entry_c.last   = last_c;
    if (push_c) begin
      mem_d[wr_ptr_q] = entry_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_ADDR;
      addr_q   <= '0;
      size_q   <= '0;
      incr_q   <= 1'b0;
      beats_q  <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hrdata_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      incr_q   <= incr_d;
      beats_q  <= beats_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      hrdata_q <= hrdata_d;
      mem_q    <= mem_d;
    end
  end

  assign head_c        = mem_q[rd_ptr_q];
  assign bus.HREADY    = hready_c;
  assign bus.HRESP     = hresp_c;
  assign bus.HRDATA    = hrdata_q;
  assign bus.req_valid = (count_q != '0);
  assign bus.req_addr  = head_c.addr;
  assign bus.req_write = head_c.write;
  assign bus.req_size  = head_c.size;
  assign bus.req_wdata = head_c.wdata;
  assign bus.req_last  = head_c.last;
endmodule
